// File: rtl/bidir_port_ctrl.sv
// bidir_port_ctrl
//   Half-duplex controller for a shared tri-state data bus. Words offered on
//   the tx side are driven onto the bus after a turnaround gap. Words the peer
//   strobes onto the bus while this block is idle are captured into a 4-entry
//   receive FIFO. Sticky flags record peer strobes seen while this block owns
//   or is turning the bus (collision) and words lost to a full FIFO (overflow).
//
//   Parameters
//     WIDTH     bus / data width
//     TURN      bus turnaround dead cycles (1..7)
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     tx_valid/tx_data      transmit word offered
//     tx_ready              transmit word accepted when tx_valid=1
//     rx_strobe             peer is driving, sample bus this cycle
//     rx_valid/rx_data      receive FIFO head (combinational)
//     rx_ready              pop receive FIFO head
//     err_clr               clear sticky error flags
//     bus                   shared half-duplex data lines
//     cntrl                 1 = this block drives bus
//     collision, overflow   sticky error flags
module bidir_port_ctrl #(
  parameter int WIDTH = 8,
  parameter int TURN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_strobe,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  input  logic             err_clr,
  inout  wire  [WIDTH-1:0] bus,
  output logic             cntrl,
  output logic             collision,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, TURN_TX, DRIVE, TURN_RX} state_t;

  localparam logic [2:0] TURN_M1 = 3'(TURN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] drv_q;

  logic             tx_hs;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             drop;
  logic             coll_set;

  logic [WIDTH-1:0] mem_q [4];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       rd_ptr_q;
  logic [2:0]       count_q;
  logic             collision_q;
  logic             overflow_q;

  // ---- direction FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- direction FSM: next state
  // A peer strobe in IDLE blocks the transmit handshake, so receive wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_valid && !rx_strobe) state_d = TURN_TX;
      TURN_TX: if (cnt_q == 3'd0)          state_d = DRIVE;
      DRIVE:   if (!tx_valid)              state_d = TURN_RX;
      TURN_RX: if (cnt_q == 3'd0)          state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // ---- direction FSM: outputs
  // tx_ready is gated by rst_n because state_q already reads IDLE during reset.
  always_comb begin
    cntrl    = (state_q == DRIVE);
    tx_ready = rst_n && ((state_q == DRIVE) || ((state_q == IDLE) && !rx_strobe));
  end

  assign tx_hs = tx_valid && tx_ready;
  assign bus   = cntrl ? drv_q : {WIDTH{1'bz}};

  // ---- transmit word register and turnaround counter
  // The counter is loaded with TURN-1 on entry to either turnaround state and
  // counts down to zero, giving exactly TURN dead cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q <= '0;
      cnt_q <= '0;
    end else begin
      if (tx_hs) drv_q <= tx_data;
      if ((state_q == IDLE) && tx_hs) begin
        cnt_q <= TURN_M1;
      end else if ((state_q == DRIVE) && !tx_valid) begin
        cnt_q <= TURN_M1;
      end else if (cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // ---- receive FIFO
  // A same-cycle pop frees the slot, so a push into a full FIFO is accepted
  // when the head is leaving at the same edge.
  assign full     = (count_q == 3'd4);
  assign push_req = (state_q == IDLE) && rx_strobe;
  assign pop      = (count_q != 3'd0) && rx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign coll_set = rx_strobe && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= bus;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  assign rx_valid = (count_q != 3'd0);
  assign rx_data  = mem_q[rd_ptr_q];

  // ---- sticky error flags: a set event in the same cycle beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      collision_q <= coll_set || (collision_q && !err_clr);
      overflow_q  <= drop     || (overflow_q  && !err_clr);
    end
  end

  assign collision = collision_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// tb_bidir_port_ctrl
//   Scoreboard bench for bidir_port_ctrl (WIDTH=8, TURN=2). The stimulus
//   process follows a cycle timeline derived from the turnaround rules and, at
//   each clock edge, pushes the words it expects to see driven (tx_exp) and
//   the words it expects the receive FIFO to hold (rxq). A monitor on the
//   falling edge pops and compares against the DUT outputs.
module tb_bidir_port_ctrl;
  localparam int WIDTH = 8;
  localparam int TURN  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_ready;
  logic             rx_strobe = 1'b0;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready = 1'b0;
  logic             err_clr = 1'b0;
  wire  [WIDTH-1:0] bus;
  logic             cntrl;
  logic             collision;
  logic             overflow;

  logic             tb_drv_en = 1'b1;
  logic [WIDTH-1:0] tb_bus_val = 8'h96;
  assign bus = tb_drv_en ? tb_bus_val : {WIDTH{1'bz}};

  bidir_port_ctrl #(.WIDTH(WIDTH), .TURN(TURN)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_strobe(rx_strobe), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .err_clr(err_clr), .bus(bus), .cntrl(cntrl),
    .collision(collision), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference state. phase: 0 idle, 1 turnaround before driving, 2 driving,
  // 3 turnaround after driving. The stimulus process sets it from the timeline.
  logic [WIDTH-1:0] tx_exp[$];
  logic [WIDTH-1:0] rxq[$];
  int               cur_phase = 0;
  bit               coll_exp = 1'b0;
  bit               ovf_exp = 1'b0;
  bit               mon_en = 1'b0;
  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- monitor
  always @(negedge clk) begin
    if (mon_en) begin
      check("cntrl", 32'(cntrl), 32'(cur_phase == 2));
      check("tx_ready", 32'(tx_ready), 32'((cur_phase == 2) || ((cur_phase == 0) && !rx_strobe)));
      if (cur_phase == 2) begin
        if (tx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_word: driving with no expected word, bus=%0h (t=%0t)", bus, $time);
        end else begin
          mon_w = tx_exp.pop_front();
          check("bus_word", 32'(bus), 32'(mon_w));
        end
      end else if (tb_drv_en) begin
        check("bus_released", 32'(bus), 32'(tb_bus_val));
      end
      check("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
      if (rxq.size() != 0) begin
        check("rx_data", 32'(rx_data), 32'(rxq[0]));
        if (rx_ready) void'(rxq.pop_front());
      end
      check("collision", 32'(collision), 32'(coll_exp));
      check("overflow", 32'(overflow), 32'(ovf_exp));
    end
  end

  // One clock edge: record what this edge should do, move to next_phase,
  // then return the single-cycle inputs to their quiet values.
  task automatic tick(input int next_phase);
    bit ovf_set;
    @(posedge clk);
    ovf_set = 1'b0;
    if ((cur_phase == 0) && rx_strobe) begin
      if (rxq.size() < 4) rxq.push_back(tb_bus_val);
      else ovf_set = 1'b1;
    end
    if (tx_valid && (((cur_phase == 0) && !rx_strobe) || (cur_phase == 2)))
      tx_exp.push_back(tx_data);
    coll_exp  = (rx_strobe && (cur_phase != 0)) || (coll_exp && !err_clr);
    ovf_exp   = ovf_set || (ovf_exp && !err_clr);
    cur_phase = next_phase;
    tb_drv_en = (next_phase != 2);
    #1;
    tb_bus_val = WIDTH'($urandom);
    tx_data    = WIDTH'($urandom);
    tx_valid   = 1'b0;
    rx_strobe  = 1'b0;
    err_clr    = 1'b0;
  endtask

  // Idle-phase cycle; tx_valid is only raised together with a strobe, so no
  // transmit handshake can start here.
  task automatic idle_cycle(input bit strobe, input logic [WIDTH-1:0] val, input bit txv, input bit clr);
    rx_strobe  = strobe;
    tb_bus_val = val;
    tx_valid   = txv && strobe;
    err_clr    = clr;
    tick(0);
  endtask

  // Burst of len words from IDLE; coll_k selects a driving cycle with a peer
  // strobe (-1 for none).
  task automatic send_burst(input int len, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                            input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3, input int coll_k);
    logic [WIDTH-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    rx_ready = 1'($urandom);
    tx_valid = 1'b1;
    tx_data  = w[0];
    tick(1);
    for (int i = 0; i < TURN; i++) begin
      rx_ready  = 1'($urandom);
      rx_strobe = ($urandom % 8) == 0;
      tx_valid  = (len > 1);
      if (len > 1) tx_data = w[1];
      tick((i == TURN - 1) ? 2 : 1);
    end
    for (int k = 0; k < len; k++) begin
      rx_ready  = 1'($urandom);
      rx_strobe = (k == coll_k);
      err_clr   = ($urandom % 4) == 0;
      tx_valid  = (k + 1 < len);
      if (k + 1 < len) tx_data = w[k + 1];
      tick((k + 1 < len) ? 2 : 3);
    end
    for (int i = 0; i < TURN; i++) begin
      rx_ready  = 1'($urandom);
      rx_strobe = ($urandom % 8) == 0;
      tx_valid  = 1'($urandom);
      tick((i == TURN - 1) ? 0 : 3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int ck;
    bit st;

    // Reset values while rst_n is low
    #1;
    check("rst_cntrl", 32'(cntrl), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_bus_released", 32'(bus), 32'(tb_bus_val));
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;

    // Single word, then the 11/22/33 burst
    send_burst(1, 8'hA5, 8'h00, 8'h00, 8'h00, -1);
    send_burst(3, 8'h11, 8'h22, 8'h33, 8'h00, -1);

    // Receive: drain first, then five strobes into a FIFO that is not read
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    rx_ready = 1'b0;
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle_cycle(1'b1, WIDTH'(8'h3C + i), 1'b0, 1'b0);
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO: pop and push 77 in the same cycle, then drain
    rx_ready = 1'b1;
    idle_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Receive priority over transmit in IDLE
    rx_ready = 1'b0;
    idle_cycle(1'b1, 8'h55, 1'b1, 1'b0);
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    rx_ready = 1'b1;
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Collision during DRIVE, then clear
    send_burst(2, 8'hAB, 8'hCD, 8'h00, 8'h00, 0);
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      if (($urandom % 3) == 0) begin
        len = 1 + int'($urandom % 4);
        ck  = (($urandom % 2) == 0) ? -1 : int'($urandom % 32'(len));
        send_burst(len, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), ck);
      end else begin
        rx_ready = 1'($urandom);
        st = 1'($urandom);
        idle_cycle(st, WIDTH'($urandom), 1'($urandom), ($urandom % 5) == 0);
      end
    end

    // Reset asserted between edges in the middle of a DRIVE burst
    rx_ready = 1'b0;
    idle_cycle(1'b1, 8'h42, 1'b0, 1'b0);
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick(1);
    tx_valid = 1'b1; tx_data = 8'hE7;
    tick(1);
    tx_valid = 1'b1; tx_data = 8'hE7;
    tick(2);
    tx_valid = 1'b1; tx_data = 8'hE7; rx_strobe = 1'b1;
    tick(2);
    tx_valid = 1'b1; tx_data = 8'h18;
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_cntrl", 32'(cntrl), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_collision", 32'(collision), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    tb_drv_en  = 1'b1;
    tb_bus_val = 8'h5A;
    #1;
    check("midrst_bus_released", 32'(bus), 32'h5A);
    @(posedge clk);
    #1;
    check("midrst_hold_tx_ready", 32'(tx_ready), 32'd0);
    check("midrst_hold_cntrl", 32'(cntrl), 32'd0);
    tx_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tx_exp.delete();
    rxq.delete();
    coll_exp  = 1'b0;
    ovf_exp   = 1'b0;
    cur_phase = 0;
    mon_en    = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send_burst(2, 8'h5C, 8'hC5, 8'h00, 8'h00, -1);
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
